aes_key_expansion_engine: RTL and testbench

//   Iterative AES key-schedule engine for AES-128/192/256, selectable per job. Takes a cipher key
//   and generates one 32-bit schedule word per cycle (FIPS-197 KeyExpansion). Emits round keys
//   0..Nr as 128-bit beats on a valid/ready stream feeding the round datapath. Replaces the

---
 rtl/aes_key_expansion_engine_pkg.sv | 15 +
 rtl/aes_key_expansion_engine_if.sv | 18 +
 rtl/aes_key_expansion_engine_subword.sv | 19 +
 rtl/aes_key_expansion_engine.sv | 102 ++++++++++
 tb/tb_aes_key_expansion_engine.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_expansion_engine_pkg.sv
// aes_key_expansion_engine_pkg: mode encodings, key-size lookups and GF(2^8) helpers
package aes_key_expansion_engine_pkg;
  typedef enum logic [1:0] {M128 = 2'b00, M192 = 2'b01, M256 = 2'b10, MBAD = 2'b11} mode_e;
  typedef enum logic {IDLE, GEN} state_e;
  localparam logic [7:0] RCON_INIT = 8'h01;
  function automatic logic [3:0] nk_of(input logic [1:0] m);
    return m == M192 ? 4'd6 : m == M256 ? 4'd8 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] m);
    return m == M192 ? 4'd12 : m == M256 ? 4'd14 : 4'd10;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_expansion_engine_if.sv
// aes_key_expansion_engine_if: job control plus round-key valid/ready stream
interface aes_key_expansion_engine_if;
  logic         start;
  logic         abort;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         done;
  logic         err;
  modport slave (input start, abort, mode, key_in, rk_ready,
                 output busy, rk_valid, rk_data, rk_index, done, err);
  modport master (output start, abort, mode, key_in, rk_ready,
                  input busy, rk_valid, rk_data, rk_index, done, err);
endinterface

// File: rtl/aes_key_expansion_engine_subword.sv
// aes_key_expansion_engine_subword: four parallel AES S-boxes on one 32-bit word
module aes_key_expansion_engine_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  for (genvar b = 0; b < 4; b++) begin : g_sb
    assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
  end
endmodule

// File: rtl/aes_key_expansion_engine.sv
// aes_key_expansion_engine: iterative AES-128/192/256 key schedule, one word per cycle, round keys streamed
module aes_key_expansion_engine
  import aes_key_expansion_engine_pkg::*;
#(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  aes_key_expansion_engine_if.slave     bus
);
  state_e         st, st_nx;
  logic [1:0]     mode_q;
  logic [255:0]   key_q;
  logic [5:0]     wi;
  logic [2:0]     md;
  logic [7:0]     rcon;
  logic [7:0][31:0] hist;
  logic [95:0]    col;
  logic           fin;
  logic [127:0]   rk_data;
  logic [3:0]     rk_index;
  logic           rk_valid, err;
  logic           legal, go, adv, last_acc;
  logic [3:0]     nk, nr;
  logic [2:0]     hidx;
  logic [31:0]    key_w, prev, sub_in, sub_out, t, w_new;
  logic [5:0]     wi_last;

  aes_key_expansion_engine_subword u_sub (.din(sub_in), .dout(sub_out));

  always_comb begin
    legal    = bus.mode == M128 || (bus.mode == M192 && ENABLE_192) || (bus.mode == M256 && ENABLE_256);
    go       = st == IDLE && bus.start && legal;
    nk       = nk_of(mode_q);
    nr       = nr_of(mode_q);
    hidx     = 3'(nk - 4'd1);
    wi_last  = {nr, 2'b11};
    adv      = st == GEN && !fin && !(rk_valid && !bus.rk_ready) && !bus.abort;
    last_acc = st == GEN && rk_valid && bus.rk_ready && rk_index == nr && !bus.abort;
    key_w    = key_q[{~wi[2:0], 5'd0} +: 32];
    prev     = hist[0];
    sub_in   = md == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    t        = md == 3'd0 ? sub_out ^ {rcon, 24'h0} : (nk == 4'd8 && md == 3'd4) ? sub_out : prev;
    w_new    = wi < {2'b00, nk} ? key_w : hist[hidx] ^ t;
    st_nx    = st == IDLE ? (go ? GEN : IDLE) : (bus.abort || last_acc ? IDLE : GEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      key_q    <= '0;
      wi       <= '0;
      md       <= '0;
      rcon     <= RCON_INIT;
      hist     <= '0;
      col      <= '0;
      fin      <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      rk_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= st == IDLE && bus.start && !legal;
      if (go) begin
        mode_q <= bus.mode;
        key_q  <= bus.key_in;
        wi     <= '0;
        md     <= '0;
        rcon   <= RCON_INIT;
        fin    <= 1'b0;
      end
      // a 4th word landing on an accept edge reloads the beat with no bubble
      if (st == GEN && bus.abort) rk_valid <= 1'b0;
      else if (adv && wi[1:0] == 2'b11) begin
        rk_valid <= 1'b1;
        rk_data  <= {col, w_new};
        rk_index <= wi[5:2];
      end else if (rk_valid && bus.rk_ready) rk_valid <= 1'b0;
      if (adv) begin
        hist <= {hist[6:0], w_new};
        col  <= {col[63:0], w_new};
        wi   <= wi + 6'd1;
        md   <= md == hidx ? 3'd0 : md + 3'd1;
        fin  <= wi == wi_last;
        if (md == 3'd0 && wi >= {2'b00, nk}) rcon <= xtime(rcon);
      end
    end
  end

  assign bus.busy     = st == GEN;
  assign bus.rk_valid = rk_valid;
  assign bus.rk_data  = rk_data;
  assign bus.rk_index = rk_index;
  assign bus.done     = last_acc;
  assign bus.err      = err;
endmodule

// File: tb/tb_aes_key_expansion_engine.sv
// tb_aes_key_expansion_engine: directed FIPS-197 vectors, backpressure, illegal mode, abort and reset
module tb_aes_key_expansion_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expansion_engine_if x();
  aes_key_expansion_engine_if y();

  aes_key_expansion_engine #(.ENABLE_192(1'b1), .ENABLE_256(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(x.slave));
  aes_key_expansion_engine #(.ENABLE_192(1'b1), .ENABLE_256(1'b0)) u_n256 (.clk(clk), .rst_n(rst_n), .bus(y.slave));

  typedef struct {
    logic [1:0]   m;
    logic [255:0] k;
    int           nb;
    logic [127:0] rk1;
    logic [127:0] msk;
    logic [127:0] rkl;
  } vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] k128_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  vec_t         v [3];
  logic [127:0] got_rk [16];
  logic [3:0]   got_ix [16];
  int n_chk = 0, n_fail = 0;
  int nb, done_cyc, done_cnt, stall_bad, stalls, err_seen;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] m, input logic [255:0] k);
    @(negedge clk);
    x.mode = m;
    x.key_in = k;
    x.start = 1'b1;
  endtask

  task automatic run_job(input bit bp);
    int hold5;
    bit fin, pst, r;
    logic [127:0] pd;
    logic [3:0] pi;
    hold5 = 0; fin = 0; pst = 0; pd = '0; pi = '0;
    nb = 0; done_cyc = -1; done_cnt = 0; stall_bad = 0; stalls = 0; err_seen = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      x.start = 1'b0;
      if (bp && c == 20) begin
        x.start = 1'b1;
        x.mode = 2'b11;
      end
      #1;
      if (pst && (x.rk_data !== pd || x.rk_index !== pi)) stall_bad++;
      if (bp && x.rk_valid && x.rk_index == 4'd5 && hold5 < 10) begin
        r = 1'b0;
        hold5++;
      end else r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      x.rk_ready = r;
      #1;
      if (x.err) err_seen++;
      if (x.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (x.rk_valid && x.rk_ready) begin
        if (nb < 16) begin
          got_rk[nb] = x.rk_data;
          got_ix[nb] = x.rk_index;
        end
        nb++;
      end
      pst = x.rk_valid && !x.rk_ready;
      if (pst) stalls++;
      pd = x.rk_data;
      pi = x.rk_index;
      if (c > 0 && !x.busy) fin = 1;
    end
    chk("job_timeout", 256'(fin), 256'(1));
    x.start = 1'b0;
    x.rk_ready = 1'b1;
  endtask

  task automatic wait_beat(input logic [3:0] idx);
    bit hit;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      x.start = 1'b0;
      #1;
      if (x.rk_valid && x.rk_index == idx) hit = 1;
    end
    chk($sformatf("wait_beat%0d", idx), 256'(hit), 256'(1));
  endtask

  task automatic check_128(input string tag);
    int bad;
    bad = 0;
    for (int j = 0; j < 11; j++) if (got_rk[j] !== k128_rk[j] || got_ix[j] !== 4'(j)) bad++;
    chk({tag, "_beats"}, 256'(nb), 256'(11));
    chk({tag, "_rk_seq_errs"}, 256'(bad), 256'(0));
    chk({tag, "_done_cnt"}, 256'(done_cnt), 256'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ixbad;
    v[0] = '{2'b00, K128, 11, 128'ha0fafe1788542cb123a339392a6c7605, {128{1'b1}},
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    v[1] = '{2'b01, K192, 13, {64'h62f8ead2522c6b7b, 64'h0}, {{64{1'b1}}, 64'h0},
             128'he98ba06f448c773c8ecc720401002202};
    v[2] = '{2'b10, K256, 15, 128'h1f352c073b6108d72d9810a30914dff4, {128{1'b1}},
             128'hfe4890d1e6188d0b046df344706c631e};
    x.start = 0; x.abort = 0; x.mode = 0; x.key_in = '0; x.rk_ready = 1;
    y.start = 0; y.abort = 0; y.mode = 0; y.key_in = '0; y.rk_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 256'({x.busy, x.rk_valid, x.done, x.err, x.rk_index, x.rk_data}), 256'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      start_job(v[i].m, v[i].k);
      run_job(1'b0);
      ixbad = 0;
      for (int j = 0; j < v[i].nb; j++) if (got_ix[j] !== 4'(j)) ixbad++;
      chk($sformatf("v%0d_beats", i), 256'(nb), 256'(v[i].nb));
      chk($sformatf("v%0d_rk0", i), 256'(got_rk[0]), 256'(v[i].k[255:128]));
      chk($sformatf("v%0d_rk1", i), 256'(got_rk[1] & v[i].msk), 256'(v[i].rk1));
      chk($sformatf("v%0d_rklast", i), 256'(got_rk[v[i].nb-1]), 256'(v[i].rkl));
      chk($sformatf("v%0d_index_errs", i), 256'(ixbad), 256'(0));
      chk($sformatf("v%0d_done_cnt", i), 256'(done_cnt), 256'(1));
      chk($sformatf("v%0d_done_cycle", i), 256'(done_cyc), 256'(4 * v[i].nb));
      if (i == 0) check_128("aes128_full");
    end

    start_job(2'b00, K128);
    run_job(1'b1);
    check_128("bp");
    chk("bp_stable_while_stalled", 256'(stall_bad), 256'(0));
    chk("bp_stalled_enough", 256'(stalls >= 10), 256'(1));
    chk("bp_start_while_busy_no_err", 256'(err_seen), 256'(0));

    @(negedge clk);
    x.mode = 2'b11; x.start = 1'b1;
    @(negedge clk);
    x.start = 1'b0;
    #1;
    chk("illegal_err_pulse", 256'({x.err, x.busy, x.rk_valid}), 256'(3'b100));
    @(negedge clk);
    #1;
    chk("illegal_err_clear", 256'({x.err, x.busy, x.rk_valid}), 256'(0));
    y.mode = 2'b10; y.key_in = K256; y.start = 1'b1;
    @(negedge clk);
    y.start = 1'b0;
    #1;
    chk("dis256_err_pulse", 256'({y.err, y.busy, y.rk_valid}), 256'(3'b100));
    @(negedge clk);
    #1;
    chk("dis256_err_clear", 256'({y.err, y.busy, y.rk_valid}), 256'(0));
    y.mode = 2'b01; y.key_in = K192; y.start = 1'b1;
    @(negedge clk);
    y.start = 1'b0;
    #1;
    chk("dis256_192_ok", 256'({y.err, y.busy}), 256'(2'b01));

    start_job(2'b00, K128);
    wait_beat(4'd3);
    x.rk_ready = 1'b0;
    x.abort = 1'b1;
    #1;
    chk("abort_no_done", 256'(x.done), 256'(0));
    @(negedge clk);
    x.abort = 1'b0;
    x.rk_ready = 1'b1;
    #1;
    chk("abort_idle", 256'({x.rk_valid, x.busy, x.done}), 256'(0));

    start_job(2'b00, K128);
    wait_beat(4'd7);
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_job", 256'({x.busy, x.rk_valid, x.done, x.err, x.rk_index, x.rk_data}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_job(2'b00, K128);
    run_job(1'b0);
    check_128("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
